// File: rtl/ofdm_pilot_pkg.sv
// Shared constants for the OFDM pilot generator: PRBS polynomial, defaults, mode encodings.
package ofdm_pilot_pkg;

   localparam int unsigned LFSR_W      = 11;
   localparam logic [10:0] LFSR_INIT   = 11'h7FF;
   // x^11 + x^2 + 1: feedback is lfsr[2] ^ lfsr[0], shifted in at the MSB
   localparam int unsigned PRBS_TAP_LO = 0;
   localparam int unsigned PRBS_TAP_HI = 2;

   localparam int unsigned CAR_W_DEF   = 11;
   localparam int unsigned N_CAR_DEF   = 1705;
   localparam int unsigned SYM_W_DEF   = 7;
   localparam int unsigned N_SYM_DEF   = 68;
   localparam int unsigned P_STEP_DEF  = 12;
   localparam int unsigned P_SHIFT_DEF = 3;

   typedef enum logic {
      MODE_SCATTERED = 1'b0,
      MODE_COMB      = 1'b1
   } pilot_mode_e;

   function automatic logic [LFSR_W-1:0] prbs_next(input logic [LFSR_W-1:0] s);
      return {s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO], s[LFSR_W-1:1]};
   endfunction

endpackage

// File: rtl/pilot_gen_if.sv
// Descriptor stream from the pilot generator to the subcarrier mapper.
interface pilot_gen_if
   import ofdm_pilot_pkg::*;
#(
   parameter int unsigned CAR_W = CAR_W_DEF,
   parameter int unsigned SYM_W = SYM_W_DEF
);
   logic             out_valid;
   logic             out_ready;
   logic [CAR_W-1:0] carrier_idx;
   logic [SYM_W-1:0] symbol_idx;
   logic             index_pilot;
   logic             sign_pilot;
   logic             last_carrier;
   logic             last_symbol;

   modport master (
      output out_valid, carrier_idx, symbol_idx, index_pilot, sign_pilot,
             last_carrier, last_symbol,
      input  out_ready
   );

   modport slave (
      input  out_valid, carrier_idx, symbol_idx, index_pilot, sign_pilot,
             last_carrier, last_symbol,
      output out_ready
   );
endinterface

// File: rtl/pilot_prbs.sv
// 11-bit pilot PRBS register: reload to all ones, or step once per emitted carrier.
module pilot_prbs
   import ofdm_pilot_pkg::*;
(
   input  logic clk,
   input  logic res_n,
   input  logic init,
   input  logic step,
   input  logic seed,
   output logic bit_out
);
   logic [LFSR_W-1:0] lfsr_q;

   // seed makes this step start from the init value (frame resync on the same load)
   always_ff @(posedge clk) begin
      if (!res_n) begin
         lfsr_q <= LFSR_INIT;
      end else if (init) begin
         lfsr_q <= LFSR_INIT;
      end else if (step) begin
         lfsr_q <= prbs_next(seed ? LFSR_INIT : lfsr_q);
      end
   end

   assign bit_out = seed ? LFSR_INIT[0] : lfsr_q[0];
endmodule

// File: rtl/pilot_gen.sv
// OFDM pilot-pattern generator: one carrier descriptor per load, scattered or comb pilots.
module pilot_gen
   import ofdm_pilot_pkg::*;
#(
   parameter int unsigned CAR_W   = CAR_W_DEF,
   parameter int unsigned N_CAR   = N_CAR_DEF,
   parameter int unsigned SYM_W   = SYM_W_DEF,
   parameter int unsigned N_SYM   = N_SYM_DEF,
   parameter int unsigned P_STEP  = P_STEP_DEF,
   parameter int unsigned P_SHIFT = P_SHIFT_DEF
) (
   input  logic        clk,
   input  logic        res_n,
   input  logic        en,
   input  logic        mode,
   input  logic        sync,
   pilot_gen_if.master dsc
);
   localparam int unsigned     M_W     = (P_STEP > 1) ? $clog2(P_STEP) : 1;
   localparam logic [CAR_W-1:0] K_LAST  = CAR_W'(N_CAR - 1);
   localparam logic [SYM_W-1:0] L_LAST  = SYM_W'(N_SYM - 1);
   localparam logic [M_W-1:0]   M_LAST  = M_W'(P_STEP - 1);
   localparam logic [M_W:0]     SHIFT_X = (M_W + 1)'(P_SHIFT);
   localparam logic [M_W:0]     STEP_X  = (M_W + 1)'(P_STEP);

   logic [CAR_W-1:0] k_q, k_d, cur_k, car_q, car_d;
   logic [SYM_W-1:0] l_q, l_d, cur_l, sym_q, sym_d;
   logic [M_W-1:0]   m_q, m_d, cur_m, o_q, o_d, cur_o, o_adv;
   logic [M_W:0]     o_sum;
   logic             sync_pend_q, sync_pend_d;
   logic             valid_q, valid_d, pilot_q, pilot_d, sign_q, sign_d;
   logic             lastc_q, lastc_d, lasts_q, lasts_d;
   logic             load, restart, k_wrap, l_wrap, prbs_bit;

   pilot_prbs u_prbs (
      .clk     (clk),
      .res_n   (res_n),
      .init    (load && k_wrap),
      .step    (load && !k_wrap),
      .seed    (restart),
      .bit_out (prbs_bit)
   );

   always_comb begin
      load    = en && (!valid_q || dsc.out_ready);
      restart = sync || sync_pend_q;
      // A resync replaces the live counters with the frame-start values for this load
      cur_k   = restart ? '0 : k_q;
      cur_l   = restart ? '0 : l_q;
      cur_m   = restart ? '0 : m_q;
      cur_o   = restart ? '0 : o_q;
      k_wrap  = (cur_k == K_LAST);
      l_wrap  = (cur_l == L_LAST);
      o_sum   = {1'b0, cur_o} + SHIFT_X;
      o_adv   = (o_sum >= STEP_X) ? M_W'(o_sum - STEP_X) : o_sum[M_W-1:0];

      k_d         = k_q;
      l_d         = l_q;
      m_d         = m_q;
      o_d         = o_q;
      car_d       = car_q;
      sym_d       = sym_q;
      pilot_d     = pilot_q;
      sign_d      = sign_q;
      lastc_d     = lastc_q;
      lasts_d     = lasts_q;
      valid_d     = valid_q && !dsc.out_ready;
      sync_pend_d = sync_pend_q || sync;

      if (load) begin
         valid_d     = 1'b1;
         sync_pend_d = 1'b0;
         car_d       = cur_k;
         sym_d       = cur_l;
         pilot_d     = (cur_m == cur_o) || (cur_k == '0) || k_wrap;
         sign_d      = prbs_bit;
         lastc_d     = k_wrap;
         lasts_d     = l_wrap;
         if (k_wrap) begin
            k_d = '0;
            m_d = '0;
            l_d = l_wrap ? '0 : cur_l + SYM_W'(1);
            o_d = (l_wrap || mode == MODE_COMB) ? '0 : o_adv;
         end else begin
            k_d = cur_k + CAR_W'(1);
            m_d = (cur_m == M_LAST) ? '0 : cur_m + M_W'(1);
            l_d = cur_l;
            o_d = cur_o;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!res_n) begin
         k_q         <= '0;
         l_q         <= '0;
         m_q         <= '0;
         o_q         <= '0;
         sync_pend_q <= 1'b0;
         valid_q     <= 1'b0;
         car_q       <= '0;
         sym_q       <= '0;
         pilot_q     <= 1'b0;
         sign_q      <= 1'b0;
         lastc_q     <= 1'b0;
         lasts_q     <= 1'b0;
      end else begin
         k_q         <= k_d;
         l_q         <= l_d;
         m_q         <= m_d;
         o_q         <= o_d;
         sync_pend_q <= sync_pend_d;
         valid_q     <= valid_d;
         car_q       <= car_d;
         sym_q       <= sym_d;
         pilot_q     <= pilot_d;
         sign_q      <= sign_d;
         lastc_q     <= lastc_d;
         lasts_q     <= lasts_d;
      end
   end

   assign dsc.out_valid    = valid_q;
   assign dsc.carrier_idx  = car_q;
   assign dsc.symbol_idx   = sym_q;
   assign dsc.index_pilot  = pilot_q;
   assign dsc.sign_pilot   = sign_q;
   assign dsc.last_carrier = lastc_q;
   assign dsc.last_symbol  = lasts_q;
endmodule

// File: tb/tb_pilot_gen.sv
// Bench for pilot_gen: reference model fills a scoreboard, accepted descriptors are popped.
module tb_pilot_gen;
   import ofdm_pilot_pkg::*;

   localparam int unsigned CAR_W   = 11;
   localparam int unsigned N_CAR   = 1705;
   localparam int unsigned SYM_W   = 7;
   localparam int unsigned N_SYM   = 6;
   localparam int unsigned P_STEP  = 12;
   localparam int unsigned P_SHIFT = 3;

   typedef struct packed {
      logic [CAR_W-1:0] k;
      logic [SYM_W-1:0] l;
      logic             pilot;
      logic             sign;
      logic             lc;
      logic             ls;
   } desc_t;

   logic clk = 1'b0;
   logic res_n, en, mode, sync;

   pilot_gen_if #(.CAR_W(CAR_W), .SYM_W(SYM_W)) dsc ();

   pilot_gen #(
      .CAR_W   (CAR_W),
      .N_CAR   (N_CAR),
      .SYM_W   (SYM_W),
      .N_SYM   (N_SYM),
      .P_STEP  (P_STEP),
      .P_SHIFT (P_SHIFT)
   ) dut (
      .clk   (clk),
      .res_n (res_n),
      .en    (en),
      .mode  (mode),
      .sync  (sync),
      .dsc   (dsc)
   );

   always #5 clk = ~clk;

   int         vectors = 0;
   int         miscompares = 0;
   desc_t      exp_q[$];
   int         mk = 0, ml = 0, mm = 0, mo = 0;
   logic [10:0] mlfsr = 11'h7FF;
   bit         mpend = 0;
   bit         bv = 0;

   function automatic desc_t dut_desc();
      return {dsc.carrier_idx, dsc.symbol_idx, dsc.index_pilot, dsc.sign_pilot,
              dsc.last_carrier, dsc.last_symbol};
   endfunction

   function automatic logic prbs_bit(input int n);
      logic [10:0] s;
      s = 11'h7FF;
      for (int i = 0; i < n; i++) s = {s[2] ^ s[0], s[10:1]};
      return s[0];
   endfunction

   // One clock: advance the model for the inputs just driven, check at negedge, return #1 after.
   task automatic step();
      desc_t e, got;
      bit    load, bv_n;
      if (!res_n) begin
         exp_q.delete();
         mk = 0; ml = 0; mm = 0; mo = 0; mlfsr = 11'h7FF; mpend = 0; bv_n = 0;
      end else begin
         load = en && (!bv || dsc.out_ready);
         if (load) begin
            if (sync || mpend) begin
               mk = 0; ml = 0; mm = 0; mo = 0; mlfsr = 11'h7FF;
            end
            e.k     = CAR_W'(mk);
            e.l     = SYM_W'(ml);
            e.pilot = (mm == mo) || (mk == 0) || (mk == N_CAR - 1);
            e.sign  = mlfsr[0];
            e.lc    = (mk == N_CAR - 1);
            e.ls    = (ml == N_SYM - 1);
            exp_q.push_back(e);
            if (mk == N_CAR - 1) begin
               mk    = 0;
               mm    = 0;
               mlfsr = 11'h7FF;
               ml    = (ml == N_SYM - 1) ? 0 : ml + 1;
               mo    = (ml == 0 || mode) ? 0 : (mo + P_SHIFT) % P_STEP;
            end else begin
               mk++;
               mm    = (mm + 1) % P_STEP;
               mlfsr = {mlfsr[2] ^ mlfsr[0], mlfsr[10:1]};
            end
            mpend = 0;
            bv_n  = 1;
         end else begin
            if (sync) mpend = 1;
            bv_n = bv && !dsc.out_ready;
         end
      end
      @(negedge clk);
      if (res_n) begin
         vectors++;
         if (dsc.out_valid !== bv) begin
            miscompares++;
            $display("FAIL out_valid: got %b, want %b", dsc.out_valid, bv);
         end
         if (dsc.out_valid && dsc.out_ready) begin
            vectors++;
            got = dut_desc();
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL scoreboard: got descriptor k=%0d l=%0d, want none", got.k, got.l);
            end else begin
               e = exp_q.pop_front();
               if (got !== e) begin
                  miscompares++;
                  $display("FAIL scoreboard: got k=%0d l=%0d p=%b s=%b lc=%b ls=%b, want k=%0d l=%0d p=%b s=%b lc=%b ls=%b",
                           got.k, got.l, got.pilot, got.sign, got.lc, got.ls,
                           e.k, e.l, e.pilot, e.sign, e.lc, e.ls);
               end
            end
         end
      end
      @(posedge clk);
      bv = bv_n;
      #1;
   endtask

   task automatic run_until(input int l, input int k, input int budget);
      bit hit;
      hit = 0;
      for (int c = 0; c < budget && !hit; c++) begin
         if (dsc.out_valid && dsc.symbol_idx == SYM_W'(l) && dsc.carrier_idx == CAR_W'(k))
            hit = 1;
         else
            step();
      end
      vectors++;
      if (!hit) begin
         miscompares++;
         $display("FAIL run_until: got no descriptor l=%0d k=%0d within %0d cycles", l, k, budget);
      end
   endtask

   task automatic check_symbol(input int l, input int off, input int chg_k, input logic chg_mode);
      int   bad, seen, k;
      bit   done;
      logic expp;
      bad = 0; seen = 0; done = 0;
      for (int c = 0; c < N_CAR + 16 && !done; c++) begin
         if (dsc.out_valid && dsc.symbol_idx == SYM_W'(l)) begin
            k    = int'(dsc.carrier_idx);
            expp = (k % P_STEP == off) || (k == 0) || (k == N_CAR - 1);
            seen++;
            if (dsc.index_pilot !== expp) bad++;
            if (k == chg_k) mode = chg_mode;
            if (k == N_CAR - 1) done = 1;
         end
         if (!done) step();
      end
      vectors++;
      if (!done || bad != 0) begin
         miscompares++;
         $display("FAIL pilots sym %0d off %0d: got %0d wrong of %0d, end=%0d; want 0 wrong, end=1",
                  l, off, bad, seen, done);
      end
   endtask

   task automatic test_reset();
      res_n = 0; en = 1; mode = 0; sync = 0; dsc.out_ready = 1;
      step();
      step();
      vectors++;
      if (dut_desc() !== '0 || dsc.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset outputs: got valid=%b desc=%h, want 0", dsc.out_valid, dut_desc());
      end
      res_n = 1; en = 0;
      step();
      vectors++;
      if (dsc.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL idle valid: got %b, want 0", dsc.out_valid);
      end
   endtask

   task automatic test_prbs();
      logic [0:21] seq;
      seq = 22'b11111111111_000000000_11;
      en = 1; mode = 0;
      for (int i = 0; i < 22; i++) begin
         step();
         vectors++;
         if (dsc.out_valid !== 1'b1 || dsc.carrier_idx !== CAR_W'(i) || dsc.sign_pilot !== seq[i]) begin
            miscompares++;
            $display("FAIL prbs k=%0d: got valid=%b k=%0d sign=%b, want valid=1 k=%0d sign=%b",
                     i, dsc.out_valid, dsc.carrier_idx, dsc.sign_pilot, i, seq[i]);
         end
      end
   endtask

   task automatic test_scattered();
      check_symbol(0, 0, -1, 1'b0);
      check_symbol(1, 3, -1, 1'b0);
      check_symbol(2, 6, -1, 1'b0);
      check_symbol(3, 9, -1, 1'b0);
      check_symbol(4, 0, -1, 1'b0);
   endtask

   task automatic test_comb();
      res_n = 0; en = 0;
      step();
      res_n = 1; en = 1; mode = 0;
      check_symbol(0, 0, -1, 1'b0);
      check_symbol(1, 3, 800, 1'b1);
      check_symbol(2, 0, -1, 1'b1);
      check_symbol(3, 0, -1, 1'b1);
   endtask

   task automatic test_backpressure();
      res_n = 0; en = 0; mode = 0;
      step();
      res_n = 1; en = 1; dsc.out_ready = 1;
      run_until(0, 100, 200);
      dsc.out_ready = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         vectors++;
         if (dsc.out_valid !== 1'b1 || dsc.carrier_idx !== CAR_W'(100)) begin
            miscompares++;
            $display("FAIL hold cycle %0d: got valid=%b k=%0d, want valid=1 k=100",
                     i, dsc.out_valid, dsc.carrier_idx);
         end
      end
      dsc.out_ready = 1;
      step();
      vectors++;
      if (dsc.carrier_idx !== CAR_W'(101) || dsc.sign_pilot !== prbs_bit(101)) begin
         miscompares++;
         $display("FAIL after hold: got k=%0d sign=%b, want k=101 sign=%b",
                  dsc.carrier_idx, dsc.sign_pilot, prbs_bit(101));
      end
   endtask

   task automatic test_wrap();
      run_until(N_SYM - 1, N_CAR - 1, N_CAR * N_SYM + 16);
      vectors++;
      if (dsc.last_carrier !== 1'b1 || dsc.last_symbol !== 1'b1) begin
         miscompares++;
         $display("FAIL frame end flags: got lc=%b ls=%b, want 1 1", dsc.last_carrier, dsc.last_symbol);
      end
      step();
      vectors++;
      if (dsc.carrier_idx !== '0 || dsc.symbol_idx !== '0 || dsc.sign_pilot !== 1'b1 ||
          dsc.last_carrier !== 1'b0 || dsc.last_symbol !== 1'b0) begin
         miscompares++;
         $display("FAIL frame wrap: got k=%0d l=%0d s=%b lc=%b ls=%b, want 0 0 1 0 0",
                  dsc.carrier_idx, dsc.symbol_idx, dsc.sign_pilot, dsc.last_carrier,
                  dsc.last_symbol);
      end
      check_symbol(0, 0, -1, 1'b0);
   endtask

   task automatic test_midframe();
      run_until(1, 500, 2 * N_CAR + 16);
      sync = 1;
      step();
      sync = 0;
      vectors++;
      if (dsc.out_valid !== 1'b1 || dsc.carrier_idx !== '0 || dsc.symbol_idx !== '0 ||
          dsc.sign_pilot !== 1'b1 || dsc.index_pilot !== 1'b1) begin
         miscompares++;
         $display("FAIL sync: got v=%b k=%0d l=%0d s=%b p=%b, want 1 0 0 1 1", dsc.out_valid,
                  dsc.carrier_idx, dsc.symbol_idx, dsc.sign_pilot, dsc.index_pilot);
      end
      for (int i = 0; i < 3; i++) step();
      dsc.out_ready = 0; sync = 1;
      step();
      sync = 0;
      step();
      vectors++;
      if (dsc.carrier_idx !== CAR_W'(3)) begin
         miscompares++;
         $display("FAIL sync under hold: got k=%0d, want 3", dsc.carrier_idx);
      end
      dsc.out_ready = 1;
      step();
      vectors++;
      if (dsc.carrier_idx !== '0 || dsc.symbol_idx !== '0 || dsc.sign_pilot !== 1'b1) begin
         miscompares++;
         $display("FAIL pending sync: got k=%0d l=%0d s=%b, want 0 0 1",
                  dsc.carrier_idx, dsc.symbol_idx, dsc.sign_pilot);
      end
      run_until(0, 800, N_CAR);
      res_n = 0;
      step();
      vectors++;
      if (dut_desc() !== '0 || dsc.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL mid reset: got valid=%b desc=%h, want 0", dsc.out_valid, dut_desc());
      end
      res_n = 1; en = 0;
      step();
      vectors++;
      if (dsc.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL post reset valid: got %b, want 0", dsc.out_valid);
      end
   endtask

   initial begin
      res_n = 0; en = 0; mode = 0; sync = 0; dsc.out_ready = 1;
      test_reset();
      test_prbs();
      test_scattered();
      test_comb();
      test_backpressure();
      test_wrap();
      test_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/pilot_gen.md
# pilot_gen

Parametrised OFDM pilot-pattern generator. It emits one descriptor per subcarrier, symbol after symbol, over a frame. Each descriptor carries the carrier index, the symbol index, a pilot flag and the PRBS-derived pilot sign. It sits between the symbol/carrier scheduler and the subcarrier mapper, where it decides for each carrier whether the carrier is a pilot or data. Compared with the fixed-table pilot lookup it replaces, it adds scattered pilots that shift per symbol, a selectable comb mode, a computed PRBS sign, a valid/ready output and a frame resync.

## Interface
Parameters:
- CAR_W, 11: carrier index width.
- N_CAR, 1705: active carriers per symbol (k = 0..N_CAR-1); N_CAR ≤ 2**CAR_W.
- SYM_W, 7: symbol index width.
- N_SYM, 68: symbols per frame; N_SYM ≤ 2**SYM_W.
- P_STEP, 12: scattered-pilot spacing in carriers; P_STEP % P_SHIFT == 0.
- P_SHIFT, 3: pilot offset advance per symbol.

Ports:
- clk, in, 1: single clock, rising edge.
- res_n, in, 1: reset, synchronous and active-low.
- en, in, 1: generation enable.
- mode, in, 1: 0 = scattered (offset shifts per symbol); 1 = comb (offset fixed at 0).
- sync, in, 1: one-cycle pulse; restart the frame at k=0, l=0.
- out_ready, in, 1: downstream accept.
- out_valid, out, 1: descriptor valid.
- carrier_idx, out, CAR_W: carrier index k.
- symbol_idx, out, SYM_W: symbol index l.
- index_pilot, out, 1: carrier k is a pilot.
- sign_pilot, out, 1: PRBS bit w_k; 1 = negative BPSK pilot.
- last_carrier, out, 1: k == N_CAR-1.
- last_symbol, out, 1: l == N_SYM-1, high for every carrier of that symbol.

## Operation
- Internal state:
  - k: carrier counter.
  - l: symbol counter.
  - m: counts 0..P_STEP-1 and wraps; cleared at each symbol start.
  - o: pilot offset for the current symbol.
  - lfsr[10:0]: PRBS register.
  - sync_pend: latched sync request.
- Load condition: `load = en && (!out_valid || out_ready)`. On load, the output register takes the current k/l descriptor and all counters advance.
- Pilot rule: `index_pilot = (m == o) || (k == 0) || (k == N_CAR-1)`. The edge carriers are always pilots.
- PRBS: polynomial x^11+x^2+1, reset to all ones at every symbol start.
  - Output bit: `sign_pilot = lfsr[0]`.
  - Advance on each load: `lfsr <= {lfsr[2]^lfsr[0], lfsr[10:1]}`.
  - The PRBS is computed for every carrier, including non-pilots.
- Carrier wrap (k == N_CAR-1 loaded):
  - k, m and lfsr reset to 0, 0 and all ones.
  - l increments; it wraps to 0 after N_SYM-1.
  - o update: o ← (o+P_SHIFT) mod P_STEP if mode==0, else 0.
  - mode is sampled only at this boundary. A mode change mid-symbol takes effect at the next symbol.
- Frame wrap: o resets to 0 at l = 0.
- sync:
  - sets sync_pend.
  - On the next load, the descriptor emitted is k=0, l=0, o=0, lfsr=all ones, and sync_pend clears.
  - A descriptor already held (out_valid && !out_ready) is not altered.
- Priority: res_n > sync > normal advance.
- en low: no new loads. A pending out_valid stays high until accepted; it is never withdrawn.

## Timing
- Reset (res_n low at a clk edge): at the next cycle all outputs are 0, k=l=m=o=0, lfsr=11'h7FF and sync_pend=0. This applies mid-operation too; an unaccepted descriptor is discarded.
- Latency: out_valid rises one cycle after the first cycle with en=1 following reset. With en=1 and out_ready=1 held, there is one descriptor per cycle, with no bubbles across carrier or symbol wrap.
- Backpressure: while out_valid && !out_ready, all outputs and internal state hold stable.
- sync asserted together with res_n low: ignored.
- sync asserted in the same cycle as a load: that load emits the k=0, l=0 descriptor.

## Structure
- Package `ofdm_pilot_pkg` holds:
  - the PRBS polynomial taps and the init value 11'h7FF;
  - the default N_CAR, N_SYM, P_STEP and P_SHIFT;
  - the mode encodings MODE_SCATTERED=0 and MODE_COMB=1.
- Sub-module `pilot_prbs` contains the 11-bit LFSR with a load-init and step interface. Everything else stays in the top module.
- Expected size is about 150–250 lines of RTL.

## Test plan
- Reset, then en=1, ready=1, mode=0:
  - carriers 0..21 give sign_pilot = 1 (×11), 0 (×9), 1, 1;
  - in symbol 0, index_pilot is set at k = 0, 12, 24, …, and at 1704.
- Scattered shift, mode=0:
  - symbols 1, 2 and 3 have pilots at k ≡ 3, 6 and 9 (mod 12) respectively;
  - symbol 4 returns to k ≡ 0;
  - k=0 and k=1704 are flagged as pilots in every symbol.
- Comb mode: mode switched to 1 mid-symbol 1. Symbol 1 stays at offset 3; symbol 2 onwards uses k ≡ 0 only.
- Backpressure: out_ready held low for 5 cycles at k=100. The descriptor holds k=100 for all 5 cycles, and the next accepted descriptor is k=101 with the correct PRBS continuation.
- Wrap: the descriptor for k=1704 in symbol 67 has last_carrier=1 and last_symbol=1. The next descriptor is k=0, l=0, with the pilot offset back at 0.
- Mid-frame events:
  - sync at k=500, l=10: the next accepted descriptor is k=0, l=0, sign=1.
  - res_n low at k=800: on the next cycle out_valid=0 and all outputs are 0.
